// File: rtl/dmem_responder_if.sv
// Request/response bus for dmem_responder. The req_be_i byte-enable field
// exists only when DMEM_BYTE_MASK_EN is defined.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  req_be_i;
`endif
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
`ifdef DMEM_BYTE_MASK_EN
    output req_be_i,
`endif
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
`ifdef DMEM_BYTE_MASK_EN
    input  req_be_i,
`endif
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed LATENCY and error checks.
// Optional per-byte store masking is enabled by defining DMEM_BYTE_MASK_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic          r_reqErr;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rspData;
  logic          r_rspErr;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]    r_be;
`endif

  logic [31:0]   r_mem [DEPTH];

  logic          w_reqErr;
  logic          w_accept;
  logic          w_done;
  logic          w_commit;

  // Out of range is equivalent to any set bit above the word-index field
  // because DEPTH is a power of two.
  assign w_reqErr = (bus.req_addr_i[1:0] != 2'b00) ||
                    (bus.req_addr_i[31:AW+2] != '0);
  assign w_accept = (r_state == S_IDLE) && bus.req_valid_i;
  assign w_done   = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_commit = w_done && r_write && !r_reqErr;

  assign bus.req_ready_o = (r_state == S_IDLE) && !rst_i;
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_rdata_o = r_rspData;
  assign bus.rsp_err_o   = r_rspErr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_reqErr  <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
`ifdef DMEM_BYTE_MASK_EN
      r_be      <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write_i;
            r_reqErr <= w_reqErr;
            r_idx    <= bus.req_addr_i[AW+1:2];
            r_wdata  <= bus.req_wdata_i;
`ifdef DMEM_BYTE_MASK_EN
            r_be     <= bus.req_be_i;
`endif
            r_cnt    <= CNT_LOAD;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            // Load data is sampled on the same edge a store would commit.
            r_rspData <= (r_write || r_reqErr) ? '0 : r_mem[r_idx];
            r_rspErr  <= r_reqErr;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            r_rspData <= '0;
            r_rspErr  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; an in-flight store is dropped by reset
  // because the state returns to IDLE before its commit edge.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
`ifdef DMEM_BYTE_MASK_EN
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
`else
      r_mem[r_idx] <= r_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=2 instance,
// plus hold, reset-abort and LATENCY=1/15 sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder_if bus1();
  dmem_responder_if bus15();

  dmem_responder #(.DEPTH(256), .LATENCY(2))  dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
  dmem_responder #(.DEPTH(16),  .LATENCY(1))  dut1  (.clk_i(clk), .rst_i(rst), .bus(bus1));
  dmem_responder #(.DEPTH(256), .LATENCY(15)) dut15 (.clk_i(clk), .rst_i(rst), .bus(bus15));

  typedef struct {
    string       name;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    bit          expErr;
  } vector_t;

  vector_t vecs[$];
  int passChecks  = 0;
  int totalChecks = 0;

  function automatic vector_t mkVec(input string name, input bit write,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [3:0] be, input logic [31:0] expData,
                                    input bit expErr);
    vector_t v;
    v.name = name; v.write = write; v.addr = addr; v.wdata = wdata;
    v.be = be; v.expData = expData; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearBus();
    bus.req_valid_i = 0;   bus.req_write_i = 0;   bus.req_addr_i = 0;
    bus.req_wdata_i = 0;   bus.rsp_ready_i = 0;
    bus1.req_valid_i = 0;  bus1.req_write_i = 0;  bus1.req_addr_i = 0;
    bus1.req_wdata_i = 0;  bus1.rsp_ready_i = 0;
    bus15.req_valid_i = 0; bus15.req_write_i = 0; bus15.req_addr_i = 0;
    bus15.req_wdata_i = 0; bus15.rsp_ready_i = 0;
`ifdef DMEM_BYTE_MASK_EN
    bus.req_be_i = 0; bus1.req_be_i = 0; bus15.req_be_i = 0;
`endif
  endtask

  // One full transaction on the LATENCY=2 instance; request fields are
  // scrambled right after acceptance to show they were latched.
  task automatic applyStimulus(input vector_t v, output int lat,
                               output logic [31:0] data, output logic err);
    @(negedge clk);
    checkOutput({v.name, " ready"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1;
    bus.req_write_i = v.write;
    bus.req_addr_i  = v.addr;
    bus.req_wdata_i = v.wdata;
`ifdef DMEM_BYTE_MASK_EN
    bus.req_be_i    = v.be;
`endif
    @(posedge clk); #1;
    bus.req_valid_i = 0;
    bus.req_write_i = ~v.write;
    bus.req_addr_i  = v.addr ^ 32'h0000_0104;
    bus.req_wdata_i = ~v.wdata;
`ifdef DMEM_BYTE_MASK_EN
    bus.req_be_i    = ~v.be;
`endif
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.rsp_valid_o) break;
    end
    data = bus.rsp_rdata_o;
    err  = bus.rsp_err_o;
    @(negedge clk);
    bus.rsp_ready_i = 1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 0;
  endtask

  task automatic runVector(input vector_t v);
    int          lat;
    logic [31:0] data;
    logic        err;
    applyStimulus(v, lat, data, err);
    checkOutput({v.name, " latency"}, 32'(lat), 32'd2);
    checkOutput({v.name, " rdata"}, data, v.expData);
    checkOutput({v.name, " err"}, 32'(err), 32'(v.expErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat1, lat15, cyc;

    clearBus();
    rst = 1;
    #12;
    checkOutput("reset req_ready", 32'(bus.req_ready_o), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("reset rdata", bus.rsp_rdata_o, 32'd0);
    checkOutput("reset err", 32'(bus.rsp_err_o), 32'd0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    checkOutput("post-reset req_ready", 32'(bus.req_ready_o), 32'd1);

    vecs.push_back(mkVec("st 0x10",       1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0));
    vecs.push_back(mkVec("ld 0x10",       0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mkVec("ld 0x13",       0, 32'h0000_0013, 32'h0,         4'h0, 32'h0, 1));
    vecs.push_back(mkVec("st 0x00",       1, 32'h0000_0000, 32'h0,         4'hF, 32'h0, 0));
    vecs.push_back(mkVec("st 0x400",      1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h0, 1));
    vecs.push_back(mkVec("ld 0x00",       0, 32'h0000_0000, 32'h0,         4'h0, 32'h0, 0));
    vecs.push_back(mkVec("st 0x20",       1, 32'h0000_0020, 32'h0,         4'hF, 32'h0, 0));
    vecs.push_back(mkVec("st 0x3FC",      1, 32'h0000_03FC, 32'h55AA_55AA, 4'hF, 32'h0, 0));
    vecs.push_back(mkVec("ld 0x3FC",      0, 32'h0000_03FC, 32'h0,         4'h0, 32'h55AA_55AA, 0));
    vecs.push_back(mkVec("ld 0x3FE",      0, 32'h0000_03FE, 32'h0,         4'h0, 32'h0, 1));
    vecs.push_back(mkVec("st 0x80000010", 1, 32'h8000_0010, 32'h7777_7777, 4'hF, 32'h0, 1));
    vecs.push_back(mkVec("ld 0x10 again", 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mkVec("ld 0x400",      0, 32'h0000_0400, 32'h0,         4'h0, 32'h0, 1));
`ifdef DMEM_BYTE_MASK_EN
    vecs.push_back(mkVec("st 0x40 full",  1, 32'h0000_0040, 32'hAABB_CCDD, 4'hF, 32'h0, 0));
    vecs.push_back(mkVec("st 0x40 be5",   1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0, 0));
    vecs.push_back(mkVec("ld 0x40 mask",  0, 32'h0000_0040, 32'h0,         4'h0, 32'hAA22_CC44, 0));
    vecs.push_back(mkVec("st 0x40 be0",   1, 32'h0000_0040, 32'h9999_9999, 4'h0, 32'h0, 0));
    vecs.push_back(mkVec("ld 0x40 be0",   0, 32'h0000_0040, 32'h0,         4'h3, 32'hAA22_CC44, 0));
`endif

    foreach (vecs[i]) runVector(vecs[i]);

    // Response held back for 5 cycles while a competing request is offered.
    @(negedge clk);
    bus.req_valid_i = 1; bus.req_write_i = 0; bus.req_addr_i = 32'h10;
    @(posedge clk); #1;
    bus.req_valid_i = 0;
    cyc = 0;
    while (cyc < 40 && !bus.rsp_valid_o) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("hold latency", 32'(cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1; bus.req_write_i = 1;
      bus.req_addr_i = 32'h10; bus.req_wdata_i = 32'h0BAD_0BAD;
      checkOutput("hold rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      checkOutput("hold rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
      checkOutput("hold err", 32'(bus.rsp_err_o), 32'd0);
      checkOutput("hold req_ready", 32'(bus.req_ready_o), 32'd0);
    end
    @(negedge clk);
    bus.req_valid_i = 0; bus.req_write_i = 0;
    bus.rsp_ready_i = 1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 0;
    checkOutput("retire rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("retire req_ready", 32'(bus.req_ready_o), 32'd1);
    runVector(mkVec("ld 0x10 post-hold", 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0));

    // Reset one cycle after accepting a store: the store must never land.
    @(negedge clk);
    bus.req_valid_i = 1; bus.req_write_i = 1;
    bus.req_addr_i = 32'h20; bus.req_wdata_i = 32'h1234_5678;
`ifdef DMEM_BYTE_MASK_EN
    bus.req_be_i = 4'hF;
`endif
    @(posedge clk); #1;
    bus.req_valid_i = 0; bus.req_write_i = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    checkOutput("abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("abort req_ready", 32'(bus.req_ready_o), 32'd0);
    checkOutput("abort rdata", bus.rsp_rdata_o, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk);
    checkOutput("abort post-reset req_ready", 32'(bus.req_ready_o), 32'd1);
    runVector(mkVec("ld 0x20 after abort", 0, 32'h20, 32'h0, 4'h0, 32'h0, 0));

    // LATENCY=1 and LATENCY=15 instances: a store then a load of the same word.
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      bus1.req_valid_i = 1;  bus1.req_write_i = (op == 0);
      bus1.req_addr_i = 32'h8; bus1.req_wdata_i = 32'hA5A5_0001;
      bus15.req_valid_i = 1; bus15.req_write_i = (op == 0);
      bus15.req_addr_i = 32'h8; bus15.req_wdata_i = 32'hA5A5_0001;
`ifdef DMEM_BYTE_MASK_EN
      bus1.req_be_i = 4'hF; bus15.req_be_i = 4'hF;
`endif
      @(posedge clk); #1;
      bus1.req_valid_i = 0; bus15.req_valid_i = 0;
      lat1 = 0; lat15 = 0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (lat1 == 0 && bus1.rsp_valid_o) lat1 = c;
        if (lat15 == 0 && bus15.rsp_valid_o) lat15 = c;
        if (lat1 != 0 && lat15 != 0) break;
      end
      checkOutput("LATENCY=1 latency", 32'(lat1), 32'd1);
      checkOutput("LATENCY=15 latency", 32'(lat15), 32'd15);
      checkOutput("LATENCY=1 rdata", bus1.rsp_rdata_o, (op == 0) ? 32'h0 : 32'hA5A5_0001);
      checkOutput("LATENCY=15 rdata", bus15.rsp_rdata_o, (op == 0) ? 32'h0 : 32'hA5A5_0001);
      @(negedge clk);
      bus1.rsp_ready_i = 1; bus15.rsp_ready_i = 1;
      @(posedge clk); #1;
      bus1.rsp_ready_i = 0; bus15.rsp_ready_i = 0;
    end

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
